// File: rtl/rv_pkg.sv
// Shared RV32I core types: the core-to-memory request struct and the
// shared-memory-port arbiter state/owner encodings.
package rv_pkg;

  typedef struct packed {
    logic [31:0] wr_data;
    logic [31:0] address;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
  } t_core2mem_req;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } t_arb_state;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } t_arb_owner;

  localparam logic [3:0] BE_WORD = 4'hF;

  // Instruction fetches are always full-word reads.
  function automatic t_core2mem_req fetch_req(input logic [31:0] addr);
    t_core2mem_req req;
    req         = '0;
    req.address = addr;
    req.rd_en   = 1'b1;
    req.byte_en = BE_WORD;
    return req;
  endfunction

endpackage

// File: rtl/rv_mem_arb_pick.sv
// Combinational grant selection for rv_mem_arb: data beats fetch unless the
// starvation guard (macro RV_MEM_ARB_STARVE_GUARD_EN) says fetch has waited enough.
module rv_mem_arb_pick
  import rv_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic             i_pend_i,
  input  logic             i_pend_d,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_gnt_valid,
  output t_arb_owner       o_gnt_owner
);

  logic w_starved;

`ifdef RV_MEM_ARB_STARVE_GUARD_EN
  assign w_starved = (i_starve_cnt == CNT_W'(STARVE_MAX));
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^i_starve_cnt;
  assign w_starved    = 1'b0;
`endif

  always_comb begin
    o_gnt_valid = i_pend_i | i_pend_d;
    o_gnt_owner = OWN_I;
    // Fetch only overrides a pending data request once it is starved.
    if (i_pend_d && !(i_pend_i && w_starved)) begin
      o_gnt_owner = OWN_D;
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Fetch/data arbiter for the single shared memory port, one transaction in flight.
// Optional fetch starvation guard enabled by macro RV_MEM_ARB_STARVE_GUARD_EN.
//
// Handshakes: a requester holds its request stable until its *_req_ready pulse
// (combinational, high in the IDLE cycle in which the request is latched);
// mem_req/mem_req_valid are registered and held until mem_req_ready; each
// *_rsp_valid is a registered one-cycle pulse to the owning requester only.
module rv_mem_arb
  import rv_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imem_req_valid,
  input  logic [31:0]   imem_addr,
  output logic          imem_req_ready,
  output logic          imem_rsp_valid,
  output logic [31:0]   imem_rsp_data,
  input  t_core2mem_req dmem_req,
  output logic          dmem_req_ready,
  output logic          dmem_rsp_valid,
  output logic [31:0]   dmem_rsp_data,
  output t_core2mem_req mem_req,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  input  logic          mem_rsp_valid,
  input  logic [31:0]   mem_rsp_data,
  output logic          busy,
  output t_arb_state    dbg_state
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  t_arb_state       r_state;
  t_arb_state       w_state_nxt;
  t_arb_owner       r_owner;
  t_core2mem_req    r_mem_req;
  logic             r_mem_req_valid;
  logic             r_imem_rsp_valid;
  logic             r_dmem_rsp_valid;
  logic [31:0]      r_imem_rsp_data;
  logic [31:0]      r_dmem_rsp_data;

  logic             w_pend_i;
  logic             w_pend_d;
  logic             w_gnt_valid;
  t_arb_owner       w_gnt_owner;
  logic             w_grant;
  logic [CNT_W-1:0] w_starve_cnt;

  assign w_pend_i = imem_req_valid;
  assign w_pend_d = dmem_req.rd_en | dmem_req.wr_en;

  rv_mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_pend_i     (w_pend_i),
    .i_pend_d     (w_pend_d),
    .i_starve_cnt (w_starve_cnt),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_owner  (w_gnt_owner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // rst_n gating keeps the ready pulses low while reset is held.
        if (w_gnt_valid && rst_n) begin
          w_grant     = 1'b1;
          w_state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_req_ready) begin
          w_state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner          <= OWN_I;
      r_mem_req        <= '0;
      r_mem_req_valid  <= 1'b0;
      r_imem_rsp_valid <= 1'b0;
      r_dmem_rsp_valid <= 1'b0;
      r_imem_rsp_data  <= '0;
      r_dmem_rsp_data  <= '0;
    end else begin
      r_imem_rsp_valid <= 1'b0;
      r_dmem_rsp_valid <= 1'b0;
      if (w_grant) begin
        r_owner         <= w_gnt_owner;
        r_mem_req       <= (w_gnt_owner == OWN_D) ? dmem_req : fetch_req(imem_addr);
        r_mem_req_valid <= 1'b1;
      end else if ((r_state == ARB_ISSUE) && mem_req_ready) begin
        r_mem_req_valid <= 1'b0;
      end
      // Responses outside WAIT have no owner and are dropped.
      if ((r_state == ARB_WAIT) && mem_rsp_valid) begin
        if (r_owner == OWN_D) begin
          r_dmem_rsp_valid <= 1'b1;
          r_dmem_rsp_data  <= mem_rsp_data;
        end else begin
          r_imem_rsp_valid <= 1'b1;
          r_imem_rsp_data  <= mem_rsp_data;
        end
      end
    end
  end

`ifdef RV_MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] r_starve_cnt;

  // Counts data grants that bypassed a waiting fetch; saturates at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant) begin
      if ((w_gnt_owner == OWN_I) || !imem_req_valid) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  assign w_starve_cnt = r_starve_cnt;
`else
  assign w_starve_cnt = '0;
`endif

  assign imem_req_ready = w_grant && (w_gnt_owner == OWN_I);
  assign dmem_req_ready = w_grant && (w_gnt_owner == OWN_D);
  assign imem_rsp_valid = r_imem_rsp_valid;
  assign imem_rsp_data  = r_imem_rsp_data;
  assign dmem_rsp_valid = r_dmem_rsp_valid;
  assign dmem_rsp_data  = r_dmem_rsp_data;
  assign mem_req        = r_mem_req;
  assign mem_req_valid  = r_mem_req_valid;
  assign busy           = (r_state != ARB_IDLE);
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb (STARVE_MAX=2): fetch/data timing, priority,
// memory stall, starvation grant order and reset abort.
module tb_rv_mem_arb;
  import rv_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          imem_req_valid;
  logic [31:0]   imem_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  t_core2mem_req dmem_req;
  logic          dmem_req_ready;
  logic          dmem_rsp_valid;
  logic [31:0]   dmem_rsp_data;
  t_core2mem_req mem_req;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          busy;
  t_arb_state    dbg_state;

  rv_mem_arb #(
    .STARVE_MAX (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dmem_req       (dmem_req),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .mem_req        (mem_req),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- memory model ----------------
  // Auto mode: ready after stall_cfg ISSUE cycles, response one cycle after acceptance.
  logic        mem_auto = 1'b1;
  int          stall_cfg = 0;
  int          issue_cnt = 0;
  logic        a_ready = 1'b1;
  logic        a_rsp_valid = 1'b0;
  logic [31:0] a_rsp_data = '0;
  logic        acc = 1'b0;
  logic [31:0] acc_addr = '0;
  logic        m_ready = 1'b0;
  logic        m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    a_rsp_valid = acc;
    a_rsp_data  = acc ? mem_word(acc_addr) : 32'h0;
    if (!mem_req_valid) issue_cnt = 0;
    a_ready = !mem_req_valid || (issue_cnt >= stall_cfg);
    if (mem_req_valid) issue_cnt++;
    acc      = mem_req_valid && a_ready;
    acc_addr = mem_req.address;
  end

  assign mem_req_ready = mem_auto ? a_ready     : m_ready;
  assign mem_rsp_valid = mem_auto ? a_rsp_valid : m_rsp_valid;
  assign mem_rsp_data  = mem_auto ? a_rsp_data  : m_rsp_data;

  // ---------------- monitor ----------------
  logic [0:0] grant_q[$];   // 1 = fetch grant, 0 = data grant
  logic [0:0] exp_q[$];
  int n_irsp = 0;
  int n_drsp = 0;

  always @(negedge clk) begin
    #1;
    if (imem_req_ready) grant_q.push_back(1'b1);
    if (dmem_req_ready) grant_q.push_back(1'b0);
    if (imem_rsp_valid) n_irsp++;
    if (dmem_rsp_valid) n_drsp++;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    dmem_req       = '0;
    rst_n          = 1'b1;
    #1 rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if ({busy, mem_req_valid, imem_req_ready, dmem_req_ready, imem_rsp_valid, dmem_rsp_valid} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, mem_req_valid, imem_req_ready,
               dmem_req_ready, imem_rsp_valid, dmem_rsp_valid});
    end
    n_checks++;
    if (mem_req !== '0) begin
      n_errors++;
      $display("FAIL reset_mem_req: got %h expected 0", mem_req);
    end
    n_checks++;
    if ({imem_rsp_data, dmem_rsp_data} !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_rsp_data: got %h %h expected 0 0", imem_rsp_data, dmem_rsp_data);
    end
    n_checks++;
    if (dbg_state !== ARB_IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ARB_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    t_core2mem_req exp_req;
    int i0, d0;
    exp_req         = '0;
    exp_req.address = 32'h100;
    exp_req.rd_en   = 1'b1;
    exp_req.byte_en = 4'hF;
    @(negedge clk);
    imem_req_valid = 1'b1;
    imem_addr      = 32'h100;
    i0 = n_irsp;
    d0 = n_drsp;
    #2;
    n_checks++;
    if ({imem_req_ready, dmem_req_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL fetch_ready_c0: got %b expected 10", {imem_req_ready, dmem_req_ready});
    end
    @(negedge clk);
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    #2;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req !== exp_req) begin
      n_errors++;
      $display("FAIL fetch_mem_req: got v=%b %h expected v=1 %h", mem_req_valid, mem_req, exp_req);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (imem_rsp_valid !== 1'b0 || dbg_state !== ARB_WAIT) begin
      n_errors++;
      $display("FAIL fetch_c2: got rsp=%b state=%0d expected rsp=0 state=%0d", imem_rsp_valid, dbg_state, ARB_WAIT);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (imem_rsp_valid !== 1'b1 || imem_rsp_data !== 32'hDEADBEEF || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_rsp_c3: got v=%b d=%h busy=%b expected v=1 d=deadbeef busy=0",
               imem_rsp_valid, imem_rsp_data, busy);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (imem_rsp_valid !== 1'b0 || (n_irsp - i0) != 1 || (n_drsp - d0) != 0) begin
      n_errors++;
      $display("FAIL fetch_pulses: got v=%b irsp=%0d drsp=%0d expected v=0 irsp=1 drsp=0",
               imem_rsp_valid, n_irsp - i0, n_drsp - d0);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    imem_req_valid   = 1'b1;
    imem_addr        = 32'h200;
    dmem_req         = '0;
    dmem_req.address = 32'h8000;
    dmem_req.rd_en   = 1'b1;
    dmem_req.byte_en = 4'hF;
    #2;
    n_checks++;
    if ({imem_req_ready, dmem_req_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL simul_ready: got %b expected 01", {imem_req_ready, dmem_req_ready});
    end
    @(negedge clk);
    dmem_req = '0;
    #2;
    n_checks++;
    if (mem_req.address !== 32'h8000 || mem_req.rd_en !== 1'b1 || mem_req.wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_data_first: got %h expected addr 8000 read", mem_req);
    end
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (dmem_rsp_valid !== 1'b1 || dmem_rsp_data !== 32'h80007FFF || imem_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL simul_b2b: got drsp=%b %h iready=%b expected 1 80007fff 1",
               dmem_rsp_valid, dmem_rsp_data, imem_req_ready);
    end
    @(negedge clk);
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    #2;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req.address !== 32'h200 || mem_req.byte_en !== 4'hF) begin
      n_errors++;
      $display("FAIL simul_fetch_issue: got v=%b %h expected addr 200", mem_req_valid, mem_req);
    end
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (imem_rsp_valid !== 1'b1 || imem_rsp_data !== 32'h0200FDFF || dmem_rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_fetch_rsp: got irsp=%b %h drsp=%b expected 1 0200fdff 0",
               imem_rsp_valid, imem_rsp_data, dmem_rsp_valid);
    end
  endtask

  task automatic test_write_stall();
    t_core2mem_req exp_req;
    int d0;
    exp_req         = '0;
    exp_req.wr_data = 32'h12345678;
    exp_req.address = 32'h40;
    exp_req.wr_en   = 1'b1;
    exp_req.byte_en = 4'b0011;
    stall_cfg = 3;
    @(negedge clk);
    dmem_req = exp_req;
    d0 = n_drsp;
    #2;
    n_checks++;
    if (dmem_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_ready: got %b expected 1", dmem_req_ready);
    end
    @(negedge clk);
    dmem_req = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req !== exp_req) begin
        n_errors++;
        $display("FAIL wr_hold_%0d: got v=%b %h expected v=1 %h", k, mem_req_valid, mem_req, exp_req);
      end
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (mem_req_valid !== 1'b0 || dmem_rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_accepted: got v=%b rsp=%b expected 0 0", mem_req_valid, dmem_rsp_valid);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (dmem_rsp_valid !== 1'b1 || imem_rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_rsp: got drsp=%b irsp=%b expected 1 0", dmem_rsp_valid, imem_rsp_valid);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (dmem_rsp_valid !== 1'b0 || (n_drsp - d0) != 1) begin
      n_errors++;
      $display("FAIL wr_one_pulse: got v=%b pulses=%0d expected 0 1", dmem_rsp_valid, n_drsp - d0);
    end
    stall_cfg = 0;
  endtask

  task automatic test_starvation();
    int cnt;
    int n_got;
    logic [0:0] g;
    logic [0:0] e;
    exp_q.delete();
`ifdef RV_MEM_ARB_STARVE_GUARD_EN
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    @(negedge clk);
    grant_q.delete();
    imem_req_valid   = 1'b1;
    imem_addr        = 32'h300;
    dmem_req         = '0;
    dmem_req.address = 32'h9000;
    dmem_req.rd_en   = 1'b1;
    dmem_req.byte_en = 4'hF;
    cnt = 0;
    while (grant_q.size() < 6 && cnt < 300) begin
      @(negedge clk);
      #2;
      cnt++;
    end
    @(negedge clk);
    dmem_req = '0;
    while (grant_q.size() < 7 && cnt < 300) begin
      @(negedge clk);
      #2;
      cnt++;
    end
    @(negedge clk);
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    repeat (6) @(negedge clk);
    #2;
    n_checks++;
    if (cnt >= 300 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL starve_timeout: got cycles=%0d busy=%b expected <300 0", cnt, busy);
    end
    n_got = grant_q.size();
    n_checks++;
    if (n_got != 7) begin
      n_errors++;
      $display("FAIL starve_count: got %0d grants expected 7", n_got);
    end
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      g = (grant_q.size() > 0) ? grant_q.pop_front() : 1'bx;
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL starve_grant_%0d: got %s expected %s", k, (g === 1'b1) ? "I" : (g === 1'b0) ? "D" : "none",
                 e ? "I" : "D");
      end
    end
  endtask

  task automatic test_reset_mid();
    int i0, d0;
    mem_auto    = 1'b0;
    m_ready     = 1'b1;
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    @(negedge clk);
    dmem_req         = '0;
    dmem_req.address = 32'hA000;
    dmem_req.rd_en   = 1'b1;
    dmem_req.byte_en = 4'hF;
    i0 = n_irsp;
    d0 = n_drsp;
    #2;
    n_checks++;
    if (dmem_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_ready: got %b expected 1", dmem_req_ready);
    end
    @(negedge clk);
    dmem_req = '0;
    @(negedge clk);
    #2;
    n_checks++;
    if (dbg_state !== ARB_WAIT || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_in_wait: got state=%0d busy=%b expected %0d 1", dbg_state, busy, ARB_WAIT);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, mem_req_valid, imem_rsp_valid, dmem_rsp_valid} !== 4'b0 || mem_req !== '0) begin
      n_errors++;
      $display("FAIL rstmid_abort: got ctrl=%b req=%h expected 0000 0",
               {busy, mem_req_valid, imem_rsp_valid, dmem_rsp_valid}, mem_req);
    end
    @(negedge clk);
    m_rsp_valid = 1'b1;
    m_rsp_data  = 32'hBAD0BAD0;
    rst_n       = 1'b1;
    @(negedge clk);
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    #2;
    n_checks++;
    if ({busy, imem_rsp_valid, dmem_rsp_valid} !== 3'b0 || {imem_rsp_data, dmem_rsp_data} !== 64'h0) begin
      n_errors++;
      $display("FAIL rstmid_late_rsp: got ctrl=%b data=%h %h expected 000 0 0",
               {busy, imem_rsp_valid, dmem_rsp_valid}, imem_rsp_data, dmem_rsp_data);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if ((n_irsp - i0) != 0 || (n_drsp - d0) != 0 || dbg_state !== ARB_IDLE) begin
      n_errors++;
      $display("FAIL rstmid_no_rsp: got irsp=%0d drsp=%0d state=%0d expected 0 0 %0d",
               n_irsp - i0, n_drsp - d0, dbg_state, ARB_IDLE);
    end
    mem_auto = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_write_stall();
    test_starvation();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
